// File: rtl/pll_seq_pkg.sv
// Shared types and default timing for the PLL reset sequencer.
// Defaults target the 50 MHz board clock feeding a 17 MHz PLL.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABILIZE = 2'd2,
    RUN       = 2'd3
  } pll_seq_state_e;

  localparam int DEF_PLL_RST_CYCLES     = 16;
  localparam int DEF_LOCK_TIMEOUT       = 1000000;
  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_TIMER_W            = 20;
  localparam int DEF_CNT_W              = 8;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous inputs.
// Synchronous active-low reset clears both stages to 0.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives PLL reset and releases core reset after lock is stable.
// Lock loss or lock timeout restarts the PLL reset pulse.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int TIMER_W            = DEF_TIMER_W,
  parameter int CNT_W              = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             locked,
  input  logic             soft_rst_req,
  output logic             pll_rst,
  output logic             core_rst_n,
  output logic             ready,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [CNT_W-1:0] retry_cnt
);

  localparam logic [TIMER_W-1:0] RST_LAST =
    TIMER_W'(PLL_RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TMO_LAST =
    TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STB_LAST =
    TIMER_W'(LOCK_STABLE_CYCLES - 1);

  pll_seq_state_e     state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]   loss_q, loss_d;
  logic [CNT_W-1:0]   retry_q, retry_d;
  logic               pll_rst_q;
  logic               core_rst_n_q;
  logic               ready_q;
  logic               locked_s;
  logic               loss_ev;
  logic               tmo_ev;

  sync_2ff u_lock_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (locked),
    .q_o    (locked_s)
  );

  always_comb begin
    state_d = state_q;
    loss_ev = 1'b0;
    tmo_ev  = 1'b0;
    case (state_q)
      PLL_RESET: begin
        if (timer_q == RST_LAST)
          state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABILIZE;
        end else if (timer_q == TMO_LAST) begin
          state_d = PLL_RESET;
          tmo_ev  = 1'b1;
        end
      end
      STABILIZE: begin
        if (!locked_s)
          state_d = WAIT_LOCK;
        else if (timer_q == STB_LAST)
          state_d = RUN;
      end
      RUN: begin
        if (!locked_s) begin
          state_d = PLL_RESET;
          loss_ev = 1'b1;
        end
      end
      default: state_d = PLL_RESET;
    endcase

    // A soft request overrides everything, including counting.
    if (soft_rst_req) begin
      state_d = PLL_RESET;
      loss_ev = 1'b0;
      tmo_ev  = 1'b0;
    end
  end

  always_comb begin
    timer_d = timer_q + 1'b1;
    if (soft_rst_req || (state_d != state_q))
      timer_d = '0;
  end

  always_comb begin
    loss_d  = loss_q;
    retry_d = retry_q;
    if (loss_ev && (loss_q != '1))
      loss_d = loss_q + 1'b1;
    if (tmo_ev && (retry_q != '1))
      retry_d = retry_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= PLL_RESET;
      timer_q      <= '0;
      loss_q       <= '0;
      retry_q      <= '0;
      pll_rst_q    <= 1'b1;
      core_rst_n_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      loss_q       <= loss_d;
      retry_q      <= retry_d;
      pll_rst_q    <= (state_d == PLL_RESET);
      core_rst_n_q <= (state_d == RUN);
      ready_q      <= (state_d == RUN);
    end
  end

  assign pll_rst       = pll_rst_q;
  assign core_rst_n    = core_rst_n_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = loss_q;
  assign retry_cnt     = retry_q;

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the PLL wrapper and consumes its `locked` output.
- Sequences the PLL's `rst` input and generates the core reset for the RV32I datapath.
- Runs on the free-running 50 MHz board clock, which is valid before lock.
- Core reset is released only after lock has been stable for a programmable time. Lock loss re-asserts core reset and restarts the PLL; a lock timeout forces a retry.

Parameters:
- PLL_RST_CYCLES, 16, cycles `pll_rst` is held high per PLL reset pulse (>=1).
- LOCK_TIMEOUT, 1000000, cycles allowed in WAIT_LOCK before a forced PLL retry (>=2).
- LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before core release (>=1).
- TIMER_W, 20, width of the shared state timer; must hold max(all three counts) - 1.
- CNT_W, 8, width of the saturating status counters.

Ports:
- clk  in  1  free-running 50 MHz reference clock (same net as the PLL refclk)
- rst_n  in  1  synchronous active-low reset
- locked  in  1  PLL lock, asynchronous to clk
- soft_rst_req  in  1  single-cycle request to restart the full sequence
- pll_rst  out  1  active-high reset to the PLL
- core_rst_n  out  1  active-low reset to the core; registered
- ready  out  1  high in RUN; registered
- lock_loss_cnt  out  CNT_W  number of lock losses seen in RUN; saturating
- retry_cnt  out  CNT_W  number of LOCK_TIMEOUT expiries; saturating

Behaviour:
- Reset:
  - Synchronous, active-low, one clock domain (clk). rst_n is sampled on the rising edge of clk.
  - While rst_n=0: state=PLL_RESET, timer=0, sync flops=0, pll_rst=1, core_rst_n=0, ready=0, both counters=0.
- Synchronizer: `locked` passes through 2 flops to give locked_s, with 2 cycles of latency. No other logic samples the raw `locked`.
- Outputs are Moore and registered, driven from the next-state value so they change on the same edge as the state:
  - pll_rst=1 only in PLL_RESET.
  - core_rst_n=1 and ready=1 only in RUN.
- Timer: cleared on every state change; otherwise increments by 1.
- PLL_RESET: when timer==PLL_RST_CYCLES-1, go to WAIT_LOCK. The pll_rst high time is therefore exactly PLL_RST_CYCLES cycles.
- WAIT_LOCK:
  - locked_s=1 -> STABILIZE.
  - Else, when timer==LOCK_TIMEOUT-1 -> PLL_RESET and retry_cnt+=1 (saturates at all-ones).
- STABILIZE:
  - locked_s=0 -> WAIT_LOCK. This is not counted as a loss, and the WAIT_LOCK timeout restarts from 0.
  - locked_s=1 and timer==LOCK_STABLE_CYCLES-1 -> RUN.
- RUN: locked_s=0 -> PLL_RESET and lock_loss_cnt+=1 (saturating). core_rst_n falls on that same edge.
- Release latency: if `locked` is stable high from edge N while in WAIT_LOCK, core_rst_n rises at edge N+2+LOCK_STABLE_CYCLES and stays high while lock holds.
- soft_rst_req=1 (rst_n=1):
  - From any state -> PLL_RESET with timer=0.
  - Highest priority after rst_n.
  - No counter increments, even if a lock loss or timeout occurs in the same cycle.
  - In PLL_RESET it restarts the pulse, extending pll_rst.
- Counters hold their values across soft_rst_req. Only rst_n clears them.
- No illegal-state lockup: unused encodings go to PLL_RESET.

Decomposition:
- Package pll_seq_pkg holds:
  - state encoding: PLL_RESET=0, WAIT_LOCK=1, STABILIZE=2, RUN=3, 2 bits;
  - default timing constants for the 50 MHz / 17 MHz configuration.
- One sub-module, sync_2ff: a generic single-bit 2-flop synchronizer with synchronous active-low reset to 0. It is reused elsewhere for asynchronous inputs.

Test Plan:
Unless noted, benches use PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE_CYCLES=8, CNT_W=4.
- Reset, then `locked` high from cycle 10 -> pll_rst high for exactly cycles 0-3 after reset release; core_rst_n rises at cycle 20 (10+2+8); ready follows.
- `locked` held low -> pll_rst pulses 4 cycles high every 36 cycles; retry_cnt=1,2,3 after each expiry; core_rst_n stays 0.
- In RUN, drop `locked` for 1 cycle -> core_rst_n=0 two edges later; lock_loss_cnt=1; pll_rst pulse of 4; re-release 10 cycles after lock is seen again.
- `locked` glitches low for 1 cycle at STABILIZE timer=5 -> return to WAIT_LOCK, no counter change; release is delayed by full re-stabilization.
- soft_rst_req in the same cycle as lock loss in RUN -> PLL_RESET, lock_loss_cnt unchanged. Then 17 induced losses -> lock_loss_cnt saturates at 15.
- rst_n low mid-STABILIZE -> all outputs return to reset values on the next edge; counters read 0.
